// File: rtl/wt_cache_pkg.sv
// wt_cache_pkg: shared types for the write-through cache EBS store path
package wt_cache_pkg;
  typedef enum logic {EBS_ARB_RR = 1'b0, EBS_ARB_PRIO = 1'b1} ebs_arb_mode_e;
  typedef struct packed {
    logic [63:0] addr;
    logic [63:0] data;
    logic [1:0]  size;
  } ebs_store_t;
  localparam int unsigned EbsTxIdBase = 2;
endpackage

// File: rtl/wt_ebs_chan_fifo.sv
// wt_ebs_chan_fifo: per-channel store buffer with full/empty/count
module wt_ebs_chan_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 130
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    push_i,
  input  logic                    pop_i,
  input  logic [Width-1:0]        data_i,
  output logic [Width-1:0]        data_o,
  output logic                    full_o,
  output logic                    empty_o,
  output logic [$clog2(Depth):0]  count_o
);
  localparam int unsigned AW = $clog2(Depth);
  logic [Width-1:0] mem_q [Depth];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0] cnt_q;
  logic wr, rd;
  assign wr = push_i && (!full_o || pop_i);
  assign rd = pop_i && !empty_o;
  assign full_o = cnt_q == (AW+1)'(Depth);
  assign empty_o = cnt_q == '0;
  assign count_o = cnt_q;
  assign data_o = mem_q[rptr_q];
  // pointers wrap naturally at Depth; a push and pop together leave the count unchanged
  always_ff @(posedge clk_i)
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q <= '0;
    end else begin
      wptr_q <= wptr_q + AW'(wr);
      rptr_q <= rptr_q + AW'(rd);
      cnt_q <= cnt_q + (AW+1)'(wr) - (AW+1)'(rd);
    end
  // storage is not reset; the count alone defines which entries are live
  always_ff @(posedge clk_i)
    if (wr) mem_q[wptr_q] <= data_i;
endmodule

// File: rtl/wt_ebs_store_arb.sv
// wt_ebs_store_arb: buffered multi-channel arbiter onto the EBS store port
module wt_ebs_store_arb
  import wt_cache_pkg::*;
#(
  parameter int unsigned NumChan   = 4,
  parameter int unsigned Depth     = 4,
  parameter int unsigned AddrWidth = 64,
  parameter int unsigned DataWidth = 64,
  parameter int unsigned CntWidth  = 16,
  parameter int unsigned TxIdBase  = EbsTxIdBase
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic                               mode_i,
  input  logic                               drop_en_i,
  input  logic                               clr_cnt_i,
  input  logic [NumChan-1:0]                 chan_valid_i,
  output logic [NumChan-1:0]                 chan_ready_o,
  input  logic [NumChan*AddrWidth-1:0]       chan_addr_i,
  input  logic [NumChan*DataWidth-1:0]       chan_data_i,
  input  logic [NumChan*2-1:0]               chan_size_i,
  output logic                               mem_req_o,
  input  logic                               mem_ack_i,
  output logic [AddrWidth-1:0]               mem_addr_o,
  output logic [DataWidth-1:0]               mem_data_o,
  output logic [1:0]                         mem_size_o,
  output logic [$clog2(TxIdBase+NumChan)-1:0] mem_tid_o,
  output logic [NumChan*CntWidth-1:0]        drop_cnt_o,
  output logic                               idle_o
);
  localparam int unsigned PW = NumChan > 1 ? $clog2(NumChan) : 1;
  localparam int unsigned TW = $clog2(TxIdBase+NumChan);
  localparam int unsigned SW = AddrWidth + DataWidth + 2;
  localparam int unsigned CW = $clog2(Depth) + 1;
  ebs_arb_mode_e mode;
  logic [NumChan-1:0] full, empty, push, pop, drop, vacant;
  logic [SW-1:0] head [NumChan];
  logic [PW-1:0] ptr_q, ptr_d, gnt;
  logic gnt_vld, load, req_q, req_d;
  logic [SW-1:0] pay_q, pay_d;
  logic [TW-1:0] tid_q, tid_d;
  assign mode = ebs_arb_mode_e'(mode_i);
  assign load = !req_q || mem_ack_i;
  assign chan_ready_o = drop_en_i ? '1 : ~full;
  assign mem_req_o = req_q;
  assign {mem_addr_o, mem_data_o, mem_size_o} = pay_q;
  assign mem_tid_o = tid_q;
  assign idle_o = !req_q && (&vacant);
  for (genvar k = 0; k < NumChan; k++) begin : g_chan
    logic [CW-1:0] count;
    logic [CntWidth-1:0] cnt_q;
    wt_ebs_chan_fifo #(.Depth(Depth), .Width(SW)) u_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (push[k]),
      .pop_i   (pop[k]),
      .data_i  ({chan_addr_i[k*AddrWidth +: AddrWidth], chan_data_i[k*DataWidth +: DataWidth], chan_size_i[2*k +: 2]}),
      .data_o  (head[k]),
      .full_o  (full[k]),
      .empty_o (empty[k]),
      .count_o (count)
    );
    assign pop[k] = load && gnt_vld && gnt == PW'(k);
    assign push[k] = chan_valid_i[k] && (!full[k] || (drop_en_i && pop[k]));
    assign drop[k] = drop_en_i && chan_valid_i[k] && full[k] && !pop[k];
    assign vacant[k] = count == '0;
    assign drop_cnt_o[k*CntWidth +: CntWidth] = cnt_q;
    // saturating drop counter; clear beats a same-cycle increment
    always_ff @(posedge clk_i)
      if (rst_i || clr_cnt_i) cnt_q <= '0;
      else if (drop[k] && !(&cnt_q)) cnt_q <= cnt_q + CntWidth'(1);
    // a size wider than the data bus cannot be carried on the store port
    always_ff @(posedge clk_i)
      if (!rst_i && chan_valid_i[k]) assert (32'(chan_size_i[2*k +: 2]) <= $clog2(DataWidth/8));
  end
  // first non-empty FIFO scanning from ptr (round-robin) or from channel 0 (fixed priority)
  always_comb begin
    int c;
    c = 0;
    gnt = '0;
    gnt_vld = 1'b0;
    for (int i = 0; i < int'(NumChan); i++) begin
      c = (mode == EBS_ARB_PRIO ? 0 : int'(ptr_q)) + i;
      if (c >= int'(NumChan)) c -= int'(NumChan);
      if (!gnt_vld && !empty[PW'(c)]) begin
        gnt = PW'(c);
        gnt_vld = 1'b1;
      end
    end
  end
  // output register refills on load and empties when nothing is eligible; ptr trails rr grants
  always_comb begin
    req_d = req_q;
    pay_d = pay_q;
    tid_d = tid_q;
    ptr_d = ptr_q;
    if (load) begin
      req_d = gnt_vld;
      if (gnt_vld) begin
        pay_d = head[gnt];
        tid_d = TW'(TxIdBase) + TW'(gnt);
        ptr_d = mode == EBS_ARB_RR ? (gnt == PW'(NumChan-1) ? '0 : gnt + PW'(1)) : ptr_q;
      end
    end
  end
  // request, payload and arbitration pointer state
  always_ff @(posedge clk_i)
    if (rst_i) begin
      req_q <= 1'b0;
      pay_q <= '0;
      tid_q <= '0;
      ptr_q <= '0;
    end else begin
      req_q <= req_d;
      pay_q <= pay_d;
      tid_q <= tid_d;
      ptr_q <= ptr_d;
    end
endmodule

// File: tb/tb_wt_ebs_store_arb.sv
// tb_wt_ebs_store_arb: table vectors, directed corner sequences and a queue-based random model
module tb_wt_ebs_store_arb;
  logic clk = 1'b0, rst = 1'b1, mode = 1'b0, den = 1'b0, clr = 1'b0, ack = 1'b0;
  logic [3:0] valid = '0;
  logic [3:0] ready;
  logic [255:0] addr = '0, data = '0;
  logic [7:0] size = '0;
  logic mem_req, idle;
  logic [63:0] mem_addr, mem_data, drop_cnt;
  logic [1:0] mem_size;
  logic [2:0] mem_tid;
  int checks = 0, errors = 0;
  int got_t[$];
  logic [63:0] got_a[$];

  typedef struct {
    logic [3:0] v; logic ack, den, clr;
    logic e_req; logic [2:0] e_tid; logic [3:0] e_rdy; logic [15:0] e_cnt2; logic e_idle;
  } vec_t;
  vec_t tbl [12];

  typedef struct { logic [63:0] a; logic [63:0] d; logic [1:0] s; } st_t;
  st_t mq [4][$];
  st_t m_st;
  logic m_ov;
  int m_tid, m_ptr;
  int mcnt [4];

  wt_ebs_store_arb dut (
    .clk_i(clk), .rst_i(rst), .mode_i(mode), .drop_en_i(den), .clr_cnt_i(clr),
    .chan_valid_i(valid), .chan_ready_o(ready), .chan_addr_i(addr), .chan_data_i(data),
    .chan_size_i(size), .mem_req_o(mem_req), .mem_ack_i(ack), .mem_addr_o(mem_addr),
    .mem_data_o(mem_data), .mem_size_o(mem_size), .mem_tid_o(mem_tid),
    .drop_cnt_o(drop_cnt), .idle_o(idle)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, a, e);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; valid = '0; ack = 1'b0; clr = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic seq(input logic [3:0] mask, input int npush, input int want);
    int k;
    k = 0;
    got_t.delete();
    got_a.delete();
    while ((k < npush || got_t.size() < want) && k < 40) begin
      valid = k < npush ? mask : 4'b0;
      for (int c = 0; c < 4; c++) begin
        addr[c*64 +: 64] = 64'(c*256 + k);
        data[c*64 +: 64] = ~64'(c*256 + k);
        size[2*c +: 2] = 2'(c);
      end
      #3;
      if (ack && mem_req) begin
        got_t.push_back(int'(mem_tid));
        got_a.push_back(mem_addr);
      end
      tick();
      k++;
    end
    valid = '0;
  endtask

  task automatic model_step();
    int sz[4];
    int g;
    g = -1;
    for (int c = 0; c < 4; c++) sz[c] = mq[c].size();
    if (!m_ov || ack) begin
      for (int i = 0; i < 4; i++) begin
        int c;
        c = mode ? i : (m_ptr + i) % 4;
        if (g < 0 && sz[c] > 0) g = c;
      end
      m_ov = g >= 0;
      if (g >= 0) begin
        m_st = mq[g].pop_front();
        m_tid = 2 + g;
        if (!mode) m_ptr = (g + 1) % 4;
      end
    end
    for (int c = 0; c < 4; c++)
      if (valid[c]) begin
        st_t s;
        s = '{addr[c*64 +: 64], data[c*64 +: 64], size[2*c +: 2]};
        if (sz[c] < 4 || (den && g == c)) mq[c].push_back(s);
        else if (den) mcnt[c] = mcnt[c] == 65535 ? 65535 : mcnt[c] + 1;
      end
    if (clr) for (int c = 0; c < 4; c++) mcnt[c] = 0;
  endtask

  initial begin
    // overflow with drop, clear, then backpressure on the full FIFO
    tbl[0]  = '{4'b0001, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 4'hf, 16'd0, 1'b1};
    tbl[1]  = '{4'b0100, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 4'hf, 16'd0, 1'b0};
    tbl[2]  = '{4'b0100, 1'b0, 1'b1, 1'b0, 1'b1, 3'd2, 4'hf, 16'd0, 1'b0};
    tbl[3]  = '{4'b0100, 1'b0, 1'b1, 1'b0, 1'b1, 3'd2, 4'hf, 16'd0, 1'b0};
    tbl[4]  = '{4'b0100, 1'b0, 1'b1, 1'b0, 1'b1, 3'd2, 4'hf, 16'd0, 1'b0};
    tbl[5]  = '{4'b0100, 1'b0, 1'b1, 1'b0, 1'b1, 3'd2, 4'hf, 16'd0, 1'b0};
    tbl[6]  = '{4'b0100, 1'b0, 1'b1, 1'b0, 1'b1, 3'd2, 4'hf, 16'd1, 1'b0};
    tbl[7]  = '{4'b0100, 1'b0, 1'b1, 1'b0, 1'b1, 3'd2, 4'hf, 16'd2, 1'b0};
    tbl[8]  = '{4'b0000, 1'b0, 1'b1, 1'b1, 1'b1, 3'd2, 4'hf, 16'd3, 1'b0};
    tbl[9]  = '{4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 3'd2, 4'hb, 16'd0, 1'b0};
    tbl[10] = '{4'b0000, 1'b1, 1'b0, 1'b0, 1'b1, 3'd2, 4'hb, 16'd0, 1'b0};
    tbl[11] = '{4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 3'd4, 4'hf, 16'd0, 1'b0};
    do_reset();
    for (int r = 0; r < 12; r++) begin
      valid = tbl[r].v; ack = tbl[r].ack; den = tbl[r].den; clr = tbl[r].clr;
      #3;
      chk($sformatf("tbl%0d_req", r), mem_req, tbl[r].e_req);
      chk($sformatf("tbl%0d_rdy", r), ready, tbl[r].e_rdy);
      chk($sformatf("tbl%0d_cnt2", r), drop_cnt[47:32], tbl[r].e_cnt2);
      chk($sformatf("tbl%0d_idle", r), idle, tbl[r].e_idle);
      if (tbl[r].e_req) chk($sformatf("tbl%0d_tid", r), mem_tid, tbl[r].e_tid);
      tick();
    end
    valid = '0; clr = 1'b0; den = 1'b0;

    // round-robin fairness: four channels, three stores each, ack held high
    do_reset();
    mode = 1'b0; ack = 1'b1;
    seq(4'hf, 3, 12);
    chk("rr_n", got_t.size(), 12);
    for (int i = 0; i < got_t.size(); i++) begin
      chk($sformatf("rr%0d_tid", i), got_t[i], 2 + i % 4);
      chk($sformatf("rr%0d_addr", i), got_a[i], 64'((i % 4) * 256 + i / 4));
    end

    // park ptr at 2, then fixed priority must ignore and preserve it
    do_reset();
    mode = 1'b0; ack = 1'b1;
    seq(4'b0010, 1, 1);
    mode = 1'b1; ack = 1'b0;
    seq(4'b1010, 2, 0);
    ack = 1'b1;
    seq(4'b0000, 0, 4);
    chk("prio_n", got_t.size(), 4);
    for (int i = 0; i < got_t.size(); i++) chk($sformatf("prio%0d_tid", i), got_t[i], i < 2 ? 3 : 5);
    mode = 1'b0;
    seq(4'b0111, 1, 3);
    chk("ptr_n", got_t.size(), 3);
    for (int i = 0; i < got_t.size(); i++) chk($sformatf("ptr%0d_tid", i), got_t[i], i == 0 ? 4 : i + 1);

    // reset values, then a request held across a delayed ack
    do_reset();
    #3;
    chk("rst_req", mem_req, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_tid", mem_tid, 0);
    chk("rst_idle", idle, 1);
    chk("rst_rdy", ready, 4'hf);
    ack = 1'b0;
    seq(4'b0001, 2, 0);
    for (int i = 0; i < 5; i++) begin
      #3;
      chk("hold_req", mem_req, 1);
      chk("hold_addr", mem_addr, 0);
      chk("hold_data", mem_data, ~64'd0);
      tick();
    end
    ack = 1'b1;
    #3;
    chk("ack_addr", mem_addr, 0);
    tick();
    ack = 1'b0;
    #3;
    chk("next_req", mem_req, 1);
    chk("next_addr", mem_addr, 1);
    chk("next_data", mem_data, ~64'd1);
    tick();

    // reset in the middle of a pending request with drops counted
    do_reset();
    den = 1'b1; ack = 1'b0;
    seq(4'b0010, 8, 0);
    #3;
    chk("mid_cnt1", drop_cnt[31:16], 3);
    chk("mid_req", mem_req, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0; den = 1'b0;
    #3;
    chk("mid_rst_req", mem_req, 0);
    chk("mid_rst_idle", idle, 1);
    chk("mid_rst_cnt", drop_cnt, 0);
    chk("mid_rst_rdy", ready, 4'hf);
    tick();

    // random traffic against the queue model
    do_reset();
    for (int c = 0; c < 4; c++) begin
      mq[c].delete();
      mcnt[c] = 0;
    end
    m_ov = 1'b0; m_ptr = 0; m_tid = 0; mode = 1'b0; den = 1'b0;
    for (int n = 0; n < 1500; n++) begin
      logic [3:0] erdy;
      logic eidle;
      if ($urandom_range(0, 19) == 0) mode = ~mode;
      if ($urandom_range(0, 29) == 0) den = ~den;
      clr = $urandom_range(0, 49) == 0;
      ack = $urandom_range(0, 9) < 6;
      valid = 4'($urandom);
      for (int c = 0; c < 4; c++) begin
        addr[c*64 +: 64] = {$urandom, $urandom};
        data[c*64 +: 64] = {$urandom, $urandom};
        size[2*c +: 2] = 2'($urandom_range(0, 3));
      end
      #3;
      eidle = !m_ov;
      for (int c = 0; c < 4; c++) begin
        erdy[c] = den || mq[c].size() < 4;
        if (mq[c].size() != 0) eidle = 1'b0;
      end
      chk("rnd_req", mem_req, m_ov);
      if (m_ov) begin
        chk("rnd_addr", mem_addr, m_st.a);
        chk("rnd_data", mem_data, m_st.d);
        chk("rnd_size", mem_size, m_st.s);
        chk("rnd_tid", mem_tid, m_tid);
      end
      chk("rnd_rdy", ready, erdy);
      chk("rnd_idle", idle, eidle);
      for (int c = 0; c < 4; c++) chk($sformatf("rnd_cnt%0d", c), drop_cnt[c*16 +: 16], mcnt[c]);
      model_step();
      tick();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
